// File: rtl/cdc_arb_pkg.sv
// ---------------------------------------------------------------------------
// cdc_arb_pkg
// Shared types and constants for the CDC channel arbiter slice.
//   state_t            : handshake FSM states (IDLE, REQ, REL)
//   DEF_*              : default parameter values used by the interface and top
//   id_w()             : width of a requester index for a given requester count
// ---------------------------------------------------------------------------
package cdc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_DATA_W         = 8;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Index width; never narrower than one bit so two requesters still get a bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdc_channel_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdc_channel_arbiter_if
// Bundles the requester side and the CDC channel side of the arbiter.
//   req_valid/req_data/req_ready : NUM_REQ requesters, word i at [i*DATA_W +: DATA_W]
//   xfer_req/xfer_data/xfer_id   : four-phase request, held word and its source index
//   xfer_ack_sync                : destination ack, already synchronized into clk
//   busy/done/timeout_err        : status
// Modports: slave = the arbiter, master = the surrounding environment.
// ---------------------------------------------------------------------------
interface cdc_channel_arbiter_if
  import cdc_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
);
  localparam int ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      xfer_req;
  logic [DATA_W-1:0]         xfer_data;
  logic [ID_W-1:0]           xfer_id;
  logic                      xfer_ack_sync;
  logic                      busy;
  logic                      done;
  logic                      timeout_err;

  modport slave (
    input  req_valid, req_data, xfer_ack_sync,
    output req_ready, xfer_req, xfer_data, xfer_id, busy, done, timeout_err
  );

  modport master (
    output req_valid, req_data, xfer_ack_sync,
    input  req_ready, xfer_req, xfer_data, xfer_id, busy, done, timeout_err
  );

endinterface

// File: rtl/cdc_channel_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick.
//   valid : NUM_REQ request vector
//   ptr   : index of the last winner (lowest priority this round)
//   grant : one-hot of the winner, zero when nothing is valid
//   idx   : winner index (0 when nothing is valid)
//   any   : at least one request is valid
// ---------------------------------------------------------------------------
module rr_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // cand_idx[k] is the index examined at priority position k: ptr+1, ptr+2, ... with wrap.
  logic [ID_W-1:0] cand_idx [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = ID_W'((int'(ptr) + gi + 1) % NUM_REQ);
  end

  always_comb begin
    idx   = '0;
    any   = 1'b0;
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && valid[cand_idx[k]]) begin
        any = 1'b1;
        idx = cand_idx[k];
      end
    end
    if (any) begin
      grant = NUM_REQ'(1) << idx;
    end
  end

endmodule

// File: rtl/cdc_channel_arbiter.sv
// ---------------------------------------------------------------------------
// cdc_channel_arbiter
// Shares one four-phase req/ack CDC channel between NUM_REQ source-domain
// requesters. Round-robin picks a winner, captures its word, then runs
// req-high / ack-high / req-low / ack-low against the synchronized ack.
//   clk, rst : source clock, synchronous active-high reset
//   bus      : cdc_channel_arbiter_if.slave (requesters, channel, status)
// Optional build macro CDC_TIMEOUT_EN adds a per-phase timeout counter that
// abandons a stuck request and raises a sticky timeout_err; without it the
// block waits on the ack indefinitely and timeout_err is tied low.
// ---------------------------------------------------------------------------
module cdc_channel_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  cdc_channel_arbiter_if.slave bus
);

  localparam int ID_W = id_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("cdc_channel_arbiter: NUM_REQ must be in 2..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("cdc_channel_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  state_t            state_reg, state_next;
  logic              xfer_req_reg, xfer_req_next;
  logic [DATA_W-1:0] xfer_data_reg, xfer_data_next;
  logic [ID_W-1:0]   xfer_id_reg, xfer_id_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;
  logic              done_reg, done_next;

  logic [DATA_W-1:0] words [NUM_REQ];
  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  logic               grant_en;
  logic               accept;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign words[gi] = bus.req_data[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .valid (bus.req_valid),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // A high ack in IDLE belongs to a transfer we no longer track (e.g. one cut
  // short by reset); granting now would confuse the destination's four-phase
  // sequence, so hold everyone off until it falls.
  assign grant_en      = (state_reg == IDLE) && !bus.xfer_ack_sync;
  assign bus.req_ready = grant_en ? arb_grant : '0;
  assign accept        = grant_en && arb_any;

`ifdef CDC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             timeout_err_reg, timeout_err_next;
  // Set when REQ was abandoned; suppresses done for that transfer.
  logic             tmo_abort_reg, tmo_abort_next;
`endif

  always_comb begin
    state_next     = state_reg;
    xfer_req_next  = xfer_req_reg;
    xfer_data_next = xfer_data_reg;
    xfer_id_next   = xfer_id_reg;
    ptr_next       = ptr_reg;
    done_next      = 1'b0;
`ifdef CDC_TIMEOUT_EN
    tmo_cnt_next     = tmo_cnt_reg;
    timeout_err_next = timeout_err_reg;
    tmo_abort_next   = tmo_abort_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (accept) begin
          xfer_data_next = words[arb_idx];
          xfer_id_next   = arb_idx;
          ptr_next       = arb_idx;
          xfer_req_next  = 1'b1;
          state_next     = REQ;
        end
      end
      REQ: begin
        if (bus.xfer_ack_sync) begin
          xfer_req_next = 1'b0;
          state_next    = REL;
        end
`ifdef CDC_TIMEOUT_EN
        else if (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          xfer_req_next    = 1'b0;
          state_next       = REL;
          timeout_err_next = 1'b1;
          tmo_abort_next   = 1'b1;
        end
`endif
      end
      REL: begin
        if (!bus.xfer_ack_sync) begin
          state_next = IDLE;
`ifdef CDC_TIMEOUT_EN
          done_next      = !tmo_abort_reg;
          tmo_abort_next = 1'b0;
`else
          done_next      = 1'b1;
`endif
        end
`ifdef CDC_TIMEOUT_EN
        else if (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_next = 1'b1;
        end
`endif
      end
      default: begin
        state_next    = IDLE;
        xfer_req_next = 1'b0;
      end
    endcase

`ifdef CDC_TIMEOUT_EN
    // Phase timer: restarts on every state change, saturates at the limit.
    if (state_next != state_reg) begin
      tmo_cnt_next = '0;
    end else if (state_reg != IDLE && tmo_cnt_reg != CNT_W'(TIMEOUT_CYCLES)) begin
      tmo_cnt_next = tmo_cnt_reg + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      xfer_req_reg  <= 1'b0;
      xfer_data_reg <= '0;
      xfer_id_reg   <= '0;
      ptr_reg       <= ID_W'(NUM_REQ - 1);
      done_reg      <= 1'b0;
`ifdef CDC_TIMEOUT_EN
      tmo_cnt_reg     <= '0;
      timeout_err_reg <= 1'b0;
      tmo_abort_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      xfer_req_reg  <= xfer_req_next;
      xfer_data_reg <= xfer_data_next;
      xfer_id_reg   <= xfer_id_next;
      ptr_reg       <= ptr_next;
      done_reg      <= done_next;
`ifdef CDC_TIMEOUT_EN
      tmo_cnt_reg     <= tmo_cnt_next;
      timeout_err_reg <= timeout_err_next;
      tmo_abort_reg   <= tmo_abort_next;
`endif
    end
  end

  assign bus.xfer_req  = xfer_req_reg;
  assign bus.xfer_data = xfer_data_reg;
  assign bus.xfer_id   = xfer_id_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = done_reg;
`ifdef CDC_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_reg;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_channel_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdc_channel_arbiter
// Self-checking bench for cdc_channel_arbiter (4 requesters, 8-bit words).
// The destination is modelled as a 2-cycle ack follower of xfer_req, with an
// override used to hold the ack at a fixed level. Expected transfers are
// queued when stimulus is driven and popped as each xfer_req rises.
// Build with +define+CDC_TIMEOUT_EN to exercise the timeout (limit 8).
// ---------------------------------------------------------------------------
module tb_cdc_channel_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int TMO = 8;

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdc_channel_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  cdc_channel_arbiter #(
    .NUM_REQ        (NR),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  // Destination model: ack follows xfer_req two clocks later unless overridden.
  logic       ack_force     = 1'b0;
  logic       ack_force_val = 1'b0;
  logic [1:0] ack_pipe      = '0;
  always @(posedge clk) ack_pipe <= {ack_pipe[0], bus.xfer_req};
  assign bus.xfer_ack_sync = ack_force ? ack_force_val : ack_pipe[1];

  // Requester-rule monitor: a pending valid must not drop before ready.
  int          proto_err = 0;
  logic [NR-1:0] pend    = '0;
  always @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      if ((pend & ~bus.req_valid) != '0) proto_err <= proto_err + 1;
      pend <= bus.req_valid & ~bus.req_ready;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.req_valid = '0;
    rst = 1'b1;
    repeat (2) tick;
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] word_fn(input int i, input int k);
    return {4'(i + 1), 4'(k)};
  endfunction

  // Feeds requesters (words_per_req words each, then valid drops) and pops the
  // scoreboard at every xfer_req rise; optionally checks back-to-back spacing.
  task automatic serve_scoreboard(input int max_ticks, input int words_per_req, input bit check_spacing);
    int            sent[NR];
    logic [NR-1:0] acc;
    logic          prev_req;
    int            last_rise;
    int            t;
    exp_t          e;
    sent      = '{default: 0};
    acc       = bus.req_valid & bus.req_ready;
    prev_req  = bus.xfer_req;
    last_rise = -1;
    for (t = 0; t < max_ticks && (exp_q.size() != 0 || bus.busy || bus.req_valid != '0); t++) begin
      tick;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          sent[i]++;
          if (sent[i] < words_per_req) bus.req_data[i*DW +: DW] = word_fn(i, sent[i]);
          else bus.req_valid[i] = 1'b0;
        end
      end
      #1;
      if (bus.xfer_req && !prev_req) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got id=%0d data=%h, required no transfer", bus.xfer_id, bus.xfer_data);
        end else begin
          e = exp_q.pop_front();
          $display("xfer id=%0d data=%h (expected id=%0d data=%h)", bus.xfer_id, bus.xfer_data, e.id, e.data);
          if (bus.xfer_id !== e.id || bus.xfer_data !== e.data) begin
            n_fail++;
            $display("FAIL sb_order: got id=%0d data=%h, required id=%0d data=%h", bus.xfer_id, bus.xfer_data, e.id, e.data);
          end
        end
        if (check_spacing && last_rise >= 0) begin
          n_checks++;
          if (t - last_rise !== 7) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles, required 7", t - last_rise);
          end
        end
        last_rise = t;
      end
      prev_req = bus.xfer_req;
      acc      = bus.req_valid & bus.req_ready;
    end
    n_checks++;
    if (exp_q.size() != 0 || bus.busy) begin
      n_fail++;
      $display("FAIL serve_timeout: got %0d pending busy=%b, required 0 pending busy=0", exp_q.size(), bus.busy);
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    bus.req_valid = '0;
    bus.req_data  = '0;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    n_checks += 7;
    if (bus.xfer_req !== 1'b0)    begin n_fail++; $display("FAIL rst_xfer_req: got %b required 0", bus.xfer_req); end
    if (bus.xfer_data !== 8'h00)  begin n_fail++; $display("FAIL rst_xfer_data: got %h required 00", bus.xfer_data); end
    if (bus.xfer_id !== 2'd0)     begin n_fail++; $display("FAIL rst_xfer_id: got %0d required 0", bus.xfer_id); end
    if (bus.busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
    if (bus.done !== 1'b0)        begin n_fail++; $display("FAIL rst_done: got %b required 0", bus.done); end
    if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err: got %b required 0", bus.timeout_err); end
    if (bus.req_ready !== 4'b0)   begin n_fail++; $display("FAIL rst_req_ready: got %b required 0000", bus.req_ready); end
  endtask

  task automatic test_single_transfer;
    int   dn;
    exp_t e;
    do_reset;
    bus.req_data[0 +: DW] = 8'hA5;
    bus.req_valid = 4'b0001;
    exp_q.push_back('{id: 2'd0, data: 8'hA5});
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b required 0001", bus.req_ready); end
    tick;
    bus.req_valid = '0;
    e = exp_q.pop_front();
    $display("xfer id=%0d data=%h (expected id=%0d data=%h)", bus.xfer_id, bus.xfer_data, e.id, e.data);
    n_checks += 4;
    if (bus.xfer_req !== 1'b1) begin n_fail++; $display("FAIL single_xfer_req: got %b required 1", bus.xfer_req); end
    if (bus.xfer_data !== e.data) begin n_fail++; $display("FAIL single_data: got %h required %h", bus.xfer_data, e.data); end
    if (bus.xfer_id !== e.id) begin n_fail++; $display("FAIL single_id: got %0d required %0d", bus.xfer_id, e.id); end
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b required 1", bus.busy); end
    dn = 0;
    repeat (20) begin
      tick;
      if (bus.done === 1'b1) begin
        dn++;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_done_busy: got %b required 0", bus.busy); end
      end
    end
    n_checks++;
    if (dn !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d required 1", dn); end
  endtask

  task automatic test_round_robin;
    do_reset;
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = word_fn(i, 0);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++)
        exp_q.push_back('{id: 2'(i), data: word_fn(i, k)});
    #1;
    serve_scoreboard(200, 2, 1'b1);
  endtask

  task automatic test_stale_ack;
    exp_t e;
    ack_force     = 1'b1;
    ack_force_val = 1'b1;
    do_reset;
    bus.req_data[1*DW +: DW] = 8'h3C;
    bus.req_valid = 4'b0010;
    repeat (5) begin
      tick;
      n_checks += 2;
      if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL stale_ready: got %b required 0000", bus.req_ready); end
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stale_busy: got %b required 0", bus.busy); end
    end
    ack_force_val = 1'b0;
    exp_q.push_back('{id: 2'd1, data: 8'h3C});
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL stale_grant: got %b required 0010", bus.req_ready); end
    tick;
    bus.req_valid = '0;
    ack_force     = 1'b0;
    e = exp_q.pop_front();
    $display("xfer id=%0d data=%h (expected id=%0d data=%h)", bus.xfer_id, bus.xfer_data, e.id, e.data);
    n_checks += 2;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL stale_busy_after: got %b required 1", bus.busy); end
    if (bus.xfer_id !== e.id || bus.xfer_data !== e.data) begin
      n_fail++;
      $display("FAIL stale_xfer: got id=%0d data=%h required id=%0d data=%h", bus.xfer_id, bus.xfer_data, e.id, e.data);
    end
    serve_scoreboard(40, 1, 1'b0);
  endtask

  task automatic test_reset_mid;
    bus.req_data[2*DW +: DW] = 8'h77;
    bus.req_valid = 4'b0100;
    tick;
    bus.req_valid = '0;
    n_checks++;
    if (bus.xfer_req !== 1'b1 || bus.xfer_id !== 2'd2) begin
      n_fail++;
      $display("FAIL mid_pre: got req=%b id=%0d required req=1 id=2", bus.xfer_req, bus.xfer_id);
    end
    rst = 1'b1;
    tick;
    n_checks += 4;
    if (bus.xfer_req !== 1'b0)   begin n_fail++; $display("FAIL mid_xfer_req: got %b required 0", bus.xfer_req); end
    if (bus.busy !== 1'b0)       begin n_fail++; $display("FAIL mid_busy: got %b required 0", bus.busy); end
    if (bus.xfer_data !== 8'h00) begin n_fail++; $display("FAIL mid_xfer_data: got %h required 00", bus.xfer_data); end
    if (bus.xfer_id !== 2'd0)    begin n_fail++; $display("FAIL mid_xfer_id: got %0d required 0", bus.xfer_id); end
    rst = 1'b0;
    // Requesters 0 and 3: a pointer left at 2 would pick 3 first.
    bus.req_data[0 +: DW]    = word_fn(0, 0);
    bus.req_data[3*DW +: DW] = word_fn(3, 0);
    bus.req_valid = 4'b1001;
    exp_q.push_back('{id: 2'd0, data: word_fn(0, 0)});
    exp_q.push_back('{id: 2'd3, data: word_fn(3, 0)});
    #1;
    serve_scoreboard(60, 1, 1'b0);
  endtask

  task automatic test_data_stability;
    exp_t          e;
    logic [DW-1:0] w;
    for (int r = 1; r < NR; r++) begin
      w = DW'($urandom);
      for (int j = 0; j < NR; j++) if (j != r) bus.req_data[j*DW +: DW] = DW'($urandom);
      bus.req_data[r*DW +: DW] = w;
      bus.req_valid = NR'(1) << r;
      exp_q.push_back('{id: 2'(r), data: w});
      tick;
      bus.req_valid = '0;
      e = exp_q.pop_front();
      $display("xfer id=%0d data=%h (expected id=%0d data=%h)", bus.xfer_id, bus.xfer_data, e.id, e.data);
      n_checks++;
      if (bus.xfer_id !== e.id || bus.xfer_data !== e.data || bus.xfer_req !== 1'b1) begin
        n_fail++;
        $display("FAIL stab_capture: got id=%0d data=%h req=%b required id=%0d data=%h req=1", bus.xfer_id, bus.xfer_data, bus.xfer_req, e.id, e.data);
      end
      for (int t = 0; t < 30 && bus.busy; t++) begin
        tick;
        bus.req_data = {$urandom, $urandom};
        if (bus.busy) begin
          n_checks++;
          if (bus.xfer_data !== e.data) begin n_fail++; $display("FAIL stab_hold: got %h required %h", bus.xfer_data, e.data); end
        end
      end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stab_end_busy: got %b required 0", bus.busy); end
    end
  endtask

`ifdef CDC_TIMEOUT_EN
  task automatic test_timeout;
    int hi, dn;
    ack_force     = 1'b1;
    ack_force_val = 1'b0;
    do_reset;
    bus.req_data[0 +: DW] = 8'h5A;
    bus.req_valid = 4'b0001;
    tick;
    bus.req_valid = '0;
    hi = 0;
    dn = 0;
    repeat (30) begin
      hi += int'(bus.xfer_req);
      dn += int'(bus.done);
      tick;
    end
    n_checks += 4;
    if (hi !== TMO) begin n_fail++; $display("FAIL tmo_req_cycles: got %0d required %0d", hi, TMO); end
    if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b required 1", bus.timeout_err); end
    if (dn !== 0) begin n_fail++; $display("FAIL tmo_done: got %0d pulses required 0", dn); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b required 0", bus.busy); end
    ack_force = 1'b0;
    do_reset;
    n_checks++;
    if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear: got %b required 0", bus.timeout_err); end
  endtask
`else
  task automatic test_timeout;
    int dn;
    ack_force     = 1'b1;
    ack_force_val = 1'b0;
    do_reset;
    bus.req_data[0 +: DW] = 8'h5A;
    bus.req_valid = 4'b0001;
    tick;
    bus.req_valid = '0;
    repeat (80) tick;
    n_checks += 3;
    if (bus.xfer_req !== 1'b1) begin n_fail++; $display("FAIL wait_req: got %b required 1", bus.xfer_req); end
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL wait_busy: got %b required 1", bus.busy); end
    if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL wait_err: got %b required 0", bus.timeout_err); end
    ack_force = 1'b0;
    dn = 0;
    repeat (20) begin
      tick;
      dn += int'(bus.done);
    end
    n_checks++;
    if (dn !== 1) begin n_fail++; $display("FAIL wait_done: got %0d pulses required 1", dn); end
  endtask
`endif

  initial begin
    test_reset;
    test_single_transfer;
    test_round_robin;
    test_stale_ack;
    test_reset_mid;
    test_data_stability;
    test_timeout;
    n_checks++;
    if (proto_err !== 0) begin n_fail++; $display("FAIL req_protocol: got %0d violations required 0", proto_err); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
